// File: rtl/mem_access_seq_if.sv
// mem_access_seq_if: data-side wishbone port between the memory-stage
// sequencer (master) and the memory system (slave).
interface mem_access_seq_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
);
   localparam int OB = $clog2(LINE_WIDTH / 8);

   logic [ADDR_WIDTH-OB-1:0] adr;
   logic [LINE_WIDTH-1:0]    dat_m;
   logic [LINE_WIDTH-1:0]    dat_s;
   logic [LINE_WIDTH/8-1:0]  sel;
   logic                     we;
   logic                     stb;
   logic                     cyc;
   logic                     ack;

   modport master (output adr, dat_m, sel, we, stb, cyc, input dat_s, ack);
   modport slave  (input adr, dat_m, sel, we, stb, cyc, output dat_s, ack);
endinterface

// File: rtl/mem_access_seq.sv
// mem_access_seq: LC-3b memory-stage access sequencer. Walks an N-level
// indirection chain (pointer reads) and then performs the final load/store
// on a wide wishbone line, generating word/byte lane selects. Holds the
// pipeline (proceed=0) until the access completes.
// Optional feature macro: ACK_TIMEOUT_EN -- aborts an access whose ACK does
// not arrive within TIMEOUT_CYCLES strobe cycles and flags err.
module mem_access_seq #(
   parameter int ADDR_WIDTH     = 16,
   parameter int WORD_WIDTH     = 16,
   parameter int LINE_WIDTH     = 128,
   parameter int MAX_IND        = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               req_valid,
   input  logic                               req_read,
   input  logic                               req_write,
   input  logic                               req_byte,
   input  logic [$clog2(MAX_IND+1)-1:0]       req_ind,
   input  logic [ADDR_WIDTH-1:0]              req_addr,
   input  logic [WORD_WIDTH-1:0]              req_wdata,
   output logic                               proceed,
   output logic [WORD_WIDTH-1:0]              rdata,
   output logic                               err,
   mem_access_seq_if.master                   wb
);
   localparam int OB    = $clog2(LINE_WIDTH / 8);
   localparam int WPL   = LINE_WIDTH / WORD_WIDTH;
   localparam int WB    = $clog2(WPL);
   localparam int WIDX  = (WB > 0) ? WB : 1;
   localparam int SEL_W = LINE_WIDTH / 8;
   localparam int LW    = $clog2(MAX_IND + 1);

   // Elaboration-time parameter sanity checks
   if (WORD_WIDTH != 16) begin : g_chk_word
      $error("mem_access_seq: WORD_WIDTH must be 16");
   end
   if ((LINE_WIDTH < WORD_WIDTH) || ((WPL & (WPL - 1)) != 0) || (LINE_WIDTH % WORD_WIDTH != 0)) begin : g_chk_line
      $error("mem_access_seq: LINE_WIDTH must be a power-of-2 multiple of WORD_WIDTH");
   end
   if (MAX_IND < 1) begin : g_chk_ind
      $error("mem_access_seq: MAX_IND must be at least 1");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_chk_to
      $error("mem_access_seq: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IND  = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   cur_addr, cur_addr_nxt;
   logic [LW-1:0]           lvl, lvl_nxt;
   logic [WORD_WIDTH-1:0]   rdata_q, rdata_nxt;

   logic                    mem_op;
   logic                    to_hit;
   logic [WIDX-1:0]         word_idx;
   logic [WORD_WIDTH-1:0]   rd_word;
   logic [7:0]              rd_byte;
   logic [WORD_WIDTH-1:0]   wdata_word;
   logic [SEL_W-1:0]        word_sel;
   logic [SEL_W-1:0]        byte_sel;
   logic [LINE_WIDTH-1:0]   line_wdata;
   logic [ADDR_WIDTH-OB-1:0] line_adr;

   // Word index within the line; bit 0 (byte offset) is ignored here
   if (WB > 0) begin : g_widx
      assign word_idx = cur_addr[OB-1:1];
   end else begin : g_widx_one
      assign word_idx = 1'b0;
   end

   assign mem_op     = req_valid && (req_read || req_write);
   assign line_adr   = cur_addr[ADDR_WIDTH-1:OB];
   assign rd_word    = wb.dat_s[WORD_WIDTH*int'(word_idx) +: WORD_WIDTH];
   assign rd_byte    = cur_addr[0] ? rd_word[15:8] : rd_word[7:0];
   assign wdata_word = req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
   assign word_sel   = SEL_W'(2'b11) << {word_idx, 1'b0};
   assign byte_sel   = SEL_W'(cur_addr[0] ? 2'b10 : 2'b01) << {word_idx, 1'b0};
   assign line_wdata = LINE_WIDTH'(wdata_word) << (WORD_WIDTH * int'(word_idx));

`ifdef ACK_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;
   logic            err_q;

   assign to_hit = wb.stb && !wb.ack && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign err    = err_q;

   // ACK wait counter: runs while strobing without ACK, clears otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (wb.stb && !wb.ack) begin
         to_cnt <= to_cnt + TO_W'(1);
      end else begin
         to_cnt <= '0;
      end
   end

   // Error flag: set for exactly the DONE cycle that follows a timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= to_hit;
      end
   end
`else
   assign to_hit = 1'b0;
   assign err    = 1'b0;
`endif

   // State and datapath registers; async reset abandons any in-flight access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cur_addr <= '0;
         lvl      <= '0;
         rdata_q  <= '0;
      end else begin
         state    <= state_nxt;
         cur_addr <= cur_addr_nxt;
         lvl      <= lvl_nxt;
         rdata_q  <= rdata_nxt;
      end
   end

   // Next-state, datapath updates and bus/pipeline outputs
   always_comb begin
      state_nxt    = state;
      cur_addr_nxt = cur_addr;
      lvl_nxt      = lvl;
      rdata_nxt    = rdata_q;
      proceed      = 1'b0;
      rdata        = '0;
      wb.adr       = '0;
      wb.dat_m     = '0;
      wb.sel       = '0;
      wb.we        = 1'b0;
      wb.stb       = 1'b0;
      wb.cyc       = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op) begin
               cur_addr_nxt = req_addr;
               lvl_nxt      = req_ind;
               state_nxt    = (req_ind != '0) ? IND : ACC;
            end else begin
               proceed = 1'b1;
            end
         end
         IND: begin
            wb.cyc = 1'b1;
            wb.stb = 1'b1;
            wb.adr = line_adr;
            wb.sel = word_sel;
            if (wb.ack) begin
               cur_addr_nxt = ADDR_WIDTH'(rd_word);
               lvl_nxt      = lvl - LW'(1);
               state_nxt    = (lvl > LW'(1)) ? IND : ACC;
            end else if (to_hit) begin
               rdata_nxt = '0;
               state_nxt = DONE;
            end else begin
               state_nxt = IND;
            end
         end
         ACC: begin
            wb.cyc   = 1'b1;
            wb.stb   = 1'b1;
            wb.we    = req_write;
            wb.adr   = line_adr;
            wb.sel   = req_byte ? byte_sel : word_sel;
            wb.dat_m = line_wdata;
            if (wb.ack) begin
               rdata_nxt = req_byte ? {8'h00, rd_byte} : rd_word;
               state_nxt = DONE;
            end else if (to_hit) begin
               rdata_nxt = '0;
               state_nxt = DONE;
            end else begin
               state_nxt = ACC;
            end
         end
         DONE: begin
            proceed   = 1'b1;
            rdata     = rdata_q;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_mem_access_seq.sv
// Testbench for mem_access_seq: table-driven directed vectors against a
// behavioural wishbone memory, plus hand sequences for reset, non-memory
// instructions and ACK wait / timeout behaviour.
module tb_mem_access_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0, req_byte = 1'b0;
   logic [1:0]  req_ind = 2'd0;
   logic [15:0] req_addr = 16'h0000, req_wdata = 16'h0000;
   logic        proceed;
   logic [15:0] rdata;
   logic        err;

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] mem [0:32767];

   mem_access_seq_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) wb ();

   mem_access_seq #(
      .ADDR_WIDTH(16), .WORD_WIDTH(16), .LINE_WIDTH(128),
      .MAX_IND(3), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
      .req_byte(req_byte), .req_ind(req_ind), .req_addr(req_addr),
      .req_wdata(req_wdata), .proceed(proceed), .rdata(rdata), .err(err),
      .wb(wb)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic         rd, wr, byt;
      logic [1:0]   ind;
      logic [15:0]  addr, wdata;
      int           dly, exp_cyc, exp_ntx;
      logic [11:0]  exp_adr0, exp_adr;
      logic [15:0]  exp_sel;
      logic         exp_we;
      logic [127:0] exp_datm;
      logic         chk_rd;
      logic [15:0]  exp_rdata;
   } vec_t;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] rd_line(input logic [11:0] a);
      logic [127:0] l;
      for (int j = 0; j < 8; j++) l[16*j +: 16] = mem[int'(a)*8 + j];
      return l;
   endfunction

   function automatic vec_t mk(input string nm, input logic rd, input logic wr, input logic byt,
                               input logic [1:0] ind, input logic [15:0] addr, input logic [15:0] wdata,
                               input int dly, input int ecyc, input int entx,
                               input logic [11:0] eadr0, input logic [11:0] eadr, input logic [15:0] esel,
                               input logic [127:0] edatm, input logic chk_rd, input logic [15:0] erd);
      vec_t v;
      v.name = nm; v.rd = rd; v.wr = wr; v.byt = byt; v.ind = ind; v.addr = addr; v.wdata = wdata;
      v.dly = dly; v.exp_cyc = ecyc; v.exp_ntx = entx; v.exp_adr0 = eadr0; v.exp_adr = eadr;
      v.exp_sel = esel; v.exp_we = wr; v.exp_datm = edatm; v.chk_rd = chk_rd; v.exp_rdata = erd;
      return v;
   endfunction

   // Apply one request and act as the wishbone slave until proceed rises
   task automatic run_vec(input vec_t v);
      int cyc, wait_n, ntx;
      logic done;
      logic [11:0] adr0, adr_l;
      logic [15:0] sel_l;
      logic we_l;
      logic [127:0] datm_l;
      adr0 = 12'h000; adr_l = 12'h000; sel_l = 16'h0000; we_l = 1'b0; datm_l = 128'h0;
      @(negedge clk);
      req_valid = 1'b1; req_read = v.rd; req_write = v.wr; req_byte = v.byt;
      req_ind = v.ind; req_addr = v.addr; req_wdata = v.wdata; wb.ack = 1'b0;
      cyc = 0; wait_n = 0; ntx = 0; done = 1'b0;
      while (!done && cyc < 200) begin
         #1;
         if (proceed) begin
            done = 1'b1;
            check({v.name, "_cycles"}, 128'(cyc), 128'(v.exp_cyc));
            check({v.name, "_ntx"}, 128'(ntx), 128'(v.exp_ntx));
            check({v.name, "_adr0"}, 128'(adr0), 128'(v.exp_adr0));
            check({v.name, "_adr"}, 128'(adr_l), 128'(v.exp_adr));
            check({v.name, "_sel"}, 128'(sel_l), 128'(v.exp_sel));
            check({v.name, "_we"}, 128'(we_l), 128'(v.exp_we));
            check({v.name, "_datm"}, datm_l, v.exp_datm);
            check({v.name, "_done_stb"}, 128'(wb.stb), 128'(0));
            check({v.name, "_err"}, 128'(err), 128'(0));
            if (v.chk_rd) check({v.name, "_rdata"}, 128'(rdata), 128'(v.exp_rdata));
            req_valid = 1'b0; wb.ack = 1'b0;
         end else if (wb.stb && wb.cyc) begin
            if (wait_n == v.dly) begin
               wb.dat_s = rd_line(wb.adr);
               wb.ack = 1'b1;
               if (ntx == 0) adr0 = wb.adr;
               adr_l = wb.adr; sel_l = wb.sel; we_l = wb.we; datm_l = wb.dat_m;
               ntx++;
               wait_n = 0;
               if (wb.we) begin
                  for (int b = 0; b < 16; b++) begin
                     if (wb.sel[b]) begin
                        if (b % 2 == 1) mem[int'(wb.adr)*8 + b/2][15:8] = wb.dat_m[8*b +: 8];
                        else            mem[int'(wb.adr)*8 + b/2][7:0]  = wb.dat_m[8*b +: 8];
                     end
                  end
               end
            end else begin
               wb.ack = 1'b0;
               wait_n++;
            end
         end else begin
            wb.ack = 1'b0;
         end
         if (!done) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!done) begin
         check({v.name, "_hang"}, 128'(0), 128'(1));
         req_valid = 1'b0; wb.ack = 1'b0;
      end
   endtask

   vec_t vecs[15];

   initial begin
      int first;
      int hi_cnt;
      wb.ack = 1'b0;
      wb.dat_s = 128'h0;
      for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
      mem[16'h1236 >> 1] = 16'hBEEF;
      mem[16'h2344 >> 1] = 16'h9A5C;
      mem[16'h0100 >> 1] = 16'h3002;
      mem[16'h3002 >> 1] = 16'h7777;
      mem[16'h0010 >> 1] = 16'h0020;
      mem[16'h0020 >> 1] = 16'h0030;
      mem[16'h0030 >> 1] = 16'h0040;

      //           name           rd    wr    byt   ind   addr      wdata     d  cyc ntx adr0     adr      sel       datm                    chk   rdata
      vecs[0]  = mk("ld_word",    1'b1, 1'b0, 1'b0, 2'd0, 16'h1236, 16'h0000, 2, 4,  1, 12'h123, 12'h123, 16'h00C0, 128'h0,                 1'b1, 16'hBEEF);
      vecs[1]  = mk("ld_word_odd",1'b1, 1'b0, 1'b0, 2'd0, 16'h1237, 16'h0000, 0, 2,  1, 12'h123, 12'h123, 16'h00C0, 128'h0,                 1'b1, 16'hBEEF);
      vecs[2]  = mk("ld_byte_hi", 1'b1, 1'b0, 1'b1, 2'd0, 16'h2345, 16'h0000, 1, 3,  1, 12'h234, 12'h234, 16'h0020, 128'h0,                 1'b1, 16'h009A);
      vecs[3]  = mk("ld_byte_lo", 1'b1, 1'b0, 1'b1, 2'd0, 16'h2344, 16'h0000, 0, 2,  1, 12'h234, 12'h234, 16'h0010, 128'h0,                 1'b1, 16'h005C);
      vecs[4]  = mk("ldi",        1'b1, 1'b0, 1'b0, 2'd1, 16'h0100, 16'h0000, 1, 5,  2, 12'h010, 12'h300, 16'h000C, 128'h0,                 1'b1, 16'h7777);
      vecs[5]  = mk("ldi_odd",    1'b1, 1'b0, 1'b0, 2'd1, 16'h0101, 16'h0000, 0, 3,  2, 12'h010, 12'h300, 16'h000C, 128'h0,                 1'b1, 16'h7777);
      vecs[6]  = mk("sti3",       1'b0, 1'b1, 1'b0, 2'd3, 16'h0010, 16'h5555, 0, 5,  4, 12'h001, 12'h004, 16'h0003, 128'h5555,             1'b0, 16'h0000);
      vecs[7]  = mk("ldbi2",      1'b1, 1'b0, 1'b1, 2'd2, 16'h0010, 16'h0000, 0, 4,  3, 12'h001, 12'h003, 16'h0001, 128'h0,                 1'b1, 16'h0040);
      vecs[8]  = mk("rd_sti3",    1'b1, 1'b0, 1'b0, 2'd0, 16'h0040, 16'h0000, 0, 2,  1, 12'h004, 12'h004, 16'h0003, 128'h0,                 1'b1, 16'h5555);
      vecs[9]  = mk("st_byte_odd",1'b0, 1'b1, 1'b1, 2'd0, 16'h0011, 16'h00A5, 1, 3,  1, 12'h001, 12'h001, 16'h0002, 128'hA5A5,             1'b0, 16'h0000);
      vecs[10] = mk("st_byte_ev", 1'b0, 1'b1, 1'b1, 2'd0, 16'h0022, 16'h12A5, 0, 2,  1, 12'h002, 12'h002, 16'h0004, 128'hA5A5 << 16,       1'b0, 16'h0000);
      vecs[11] = mk("st_word",    1'b0, 1'b1, 1'b0, 2'd0, 16'h004E, 16'hCAFE, 0, 2,  1, 12'h004, 12'h004, 16'hC000, 128'hCAFE << 112,      1'b0, 16'h0000);
      vecs[12] = mk("st_conflict",1'b1, 1'b1, 1'b0, 2'd0, 16'h0050, 16'h1234, 0, 2,  1, 12'h005, 12'h005, 16'h0003, 128'h1234,             1'b0, 16'h0000);
      vecs[13] = mk("rd_bytest",  1'b1, 1'b0, 1'b0, 2'd0, 16'h0010, 16'h0000, 0, 2,  1, 12'h001, 12'h001, 16'h0003, 128'h0,                 1'b1, 16'hA520);
      vecs[14] = mk("rd_conflict",1'b1, 1'b0, 1'b0, 2'd0, 16'h0050, 16'h0000, 3, 5,  1, 12'h005, 12'h005, 16'h0003, 128'h0,                 1'b1, 16'h1234);

      // Reset state
      #1;
      check("rst_proceed", 128'(proceed), 128'(1));
      check("rst_stb", 128'(wb.stb), 128'(0));
      check("rst_cyc", 128'(wb.cyc), 128'(0));
      check("rst_we", 128'(wb.we), 128'(0));
      check("rst_err", 128'(err), 128'(0));
      check("rst_rdata", 128'(rdata), 128'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Non-memory instruction passes straight through
      req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0; req_ind = 2'd2; req_addr = 16'h1236;
      #1;
      check("nonmem_proceed", 128'(proceed), 128'(1));
      check("nonmem_stb", 128'(wb.stb), 128'(0));
      @(negedge clk); #1;
      check("nonmem_proceed2", 128'(proceed), 128'(1));
      check("nonmem_cyc2", 128'(wb.cyc), 128'(0));
      req_valid = 1'b0; req_read = 1'b1; req_ind = 2'd0;
      #1;
      check("novalid_proceed", 128'(proceed), 128'(1));
      req_read = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset during second ACC wait cycle; a later ACK must be ignored
      @(negedge clk);
      req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_byte = 1'b0;
      req_ind = 2'd0; req_addr = 16'h1236; wb.ack = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      check("midrst_stb_before", 128'(wb.stb), 128'(1));
      rst = 1'b1;
      #1;
      check("midrst_stb", 128'(wb.stb), 128'(0));
      check("midrst_cyc", 128'(wb.cyc), 128'(0));
      check("midrst_proceed_held", 128'(proceed), 128'(0));
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0; req_read = 1'b0;
      wb.dat_s = rd_line(12'h123); wb.ack = 1'b1;
      #1;
      check("midrst_idle_proceed", 128'(proceed), 128'(1));
      @(negedge clk);
      wb.ack = 1'b0;
      #1;
      check("midrst_late_ack_proceed", 128'(proceed), 128'(1));
      check("midrst_late_ack_stb", 128'(wb.stb), 128'(0));
      check("midrst_late_ack_rdata", 128'(rdata), 128'(0));

`ifdef ACK_TIMEOUT_EN
      // Load whose ACK never comes: aborts with err in cycle 9
      @(negedge clk);
      req_valid = 1'b1; req_read = 1'b1; req_addr = 16'h1236;
      first = -1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk); #1;
         if (c == 8) check("to_err_early", 128'(err), 128'(0));
         if (proceed && first < 0) begin
            first = c;
            check("to_err", 128'(err), 128'(1));
            check("to_rdata", 128'(rdata), 128'(0));
            check("to_stb", 128'(wb.stb), 128'(0));
            req_valid = 1'b0;
         end
      end
      check("to_cycle", 128'(first), 128'(9));
      req_valid = 1'b0; req_read = 1'b0;
`else
      // Without the timeout the sequencer waits as long as ACK takes
      @(negedge clk);
      req_valid = 1'b1; req_read = 1'b1; req_addr = 16'h1236;
      hi_cnt = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk); #1;
         if (proceed || err) hi_cnt++;
      end
      check("wait_no_proceed", 128'(hi_cnt), 128'(0));
      check("wait_stb", 128'(wb.stb), 128'(1));
      wb.dat_s = rd_line(wb.adr); wb.ack = 1'b1;
      @(negedge clk);
      wb.ack = 1'b0;
      #1;
      check("wait_proceed", 128'(proceed), 128'(1));
      check("wait_rdata", 128'(rdata), 128'(16'hBEEF));
      check("wait_err", 128'(err), 128'(0));
      req_valid = 1'b0; req_read = 1'b0;
      first = 0;
`endif

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
